// File: rtl/dma_read_req_scheduler.sv
// rtl/dma_read_req_scheduler.sv - DMA read command scheduler: tracker allocation then beat-aligned memory requests (optional perf counters via DMA_READ_REQ_SCHED_PERF_EN)
module dma_read_req_scheduler #(
   parameter int BYTE_WIDTH = 15,
   parameter int ADDR_W     = 40,
   parameter int BEAT_BYTES = 64,
   parameter int LEN_W      = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_cmd_valid,
   output logic                  io_cmd_ready,
   input  logic [5:0]            io_cmd_bits_tag_rob_id,
   input  logic [ADDR_W-1:0]     io_cmd_bits_vaddr,
   input  logic [BYTE_WIDTH-1:0] io_cmd_bits_bytes,
   output logic                  io_alloc_valid,
   input  logic                  io_alloc_ready,
   output logic [5:0]            io_alloc_bits_tag_rob_id,
   output logic [BYTE_WIDTH-1:0] io_alloc_bits_bytes_to_read,
   input  logic                  io_alloc_bits_cmd_id,
   output logic                  io_req_valid,
   input  logic                  io_req_ready,
   output logic [ADDR_W-1:0]     io_req_bits_addr,
   output logic [LEN_W-1:0]      io_req_bits_bytes,
   output logic                  io_req_bits_cmd_id,
   output logic                  io_busy
`ifdef DMA_READ_REQ_SCHED_PERF_EN
   ,
   output logic [31:0]           io_perf_cmds,
   output logic [31:0]           io_perf_alloc_stall,
   output logic [31:0]           io_perf_req_stall
`endif
);

   localparam int OFF_W = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALLOC = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            tag_q, tag_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [BYTE_WIDTH-1:0] rem_q, rem_d;
   logic [BYTE_WIDTH-1:0] total_q, total_d;
   logic                  id_q, id_d;

   // Chunk size: stop at the next beat boundary or at the end of the transfer.
   logic [OFF_W-1:0] beat_off;
   logic [LEN_W-1:0] room;
   logic [LEN_W-1:0] chunk;
   logic             last_chunk;

   assign beat_off   = addr_q[OFF_W-1:0];
   assign room       = LEN_W'(BEAT_BYTES) - LEN_W'(beat_off);
   assign chunk      = (rem_q < BYTE_WIDTH'(room)) ? rem_q[LEN_W-1:0] : room;
   assign last_chunk = (BYTE_WIDTH'(chunk) == rem_q);

   // All outputs come from state and registered payload only.
   assign io_cmd_ready                = (state_q == IDLE);
   assign io_alloc_valid              = (state_q == ALLOC);
   assign io_alloc_bits_tag_rob_id    = tag_q;
   assign io_alloc_bits_bytes_to_read = total_q;
   assign io_req_valid                = (state_q == ISSUE);
   assign io_req_bits_addr            = addr_q;
   assign io_req_bits_bytes           = chunk;
   assign io_req_bits_cmd_id          = id_q;
   assign io_busy                     = (state_q != IDLE);

   // Next-state and datapath update for the command/alloc/issue sequence.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      total_d = total_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (io_cmd_valid) begin
               tag_d   = io_cmd_bits_tag_rob_id;
               addr_d  = io_cmd_bits_vaddr;
               rem_d   = io_cmd_bits_bytes;
               total_d = io_cmd_bits_bytes;
               // A zero-length command is swallowed without touching the tracker.
               if (io_cmd_bits_bytes != '0) begin
                  state_d = ALLOC;
               end
            end
         end
         ALLOC: begin
            if (io_alloc_ready) begin
               id_d    = io_alloc_bits_cmd_id;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (io_req_ready) begin
               // Address wraps silently at 2^ADDR_W.
               addr_d = addr_q + ADDR_W'(chunk);
               rem_d  = rem_q - BYTE_WIDTH'(chunk);
               if (last_chunk) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command payload registers; reset abandons any in-flight command.
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         total_q <= '0;
         id_q    <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         total_q <= total_d;
         id_q    <= id_d;
      end
   end

`ifdef DMA_READ_REQ_SCHED_PERF_EN
   logic [31:0] perf_cmds_q;
   logic [31:0] perf_alloc_stall_q;
   logic [31:0] perf_req_stall_q;

   assign io_perf_cmds        = perf_cmds_q;
   assign io_perf_alloc_stall = perf_alloc_stall_q;
   assign io_perf_req_stall   = perf_req_stall_q;

   // Saturating event counters: completed commands and stall cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_cmds_q        <= '0;
         perf_alloc_stall_q <= '0;
         perf_req_stall_q   <= '0;
      end else begin
         if (state_q == ISSUE && io_req_ready && last_chunk && perf_cmds_q != '1) begin
            perf_cmds_q <= perf_cmds_q + 32'd1;
         end
         if (state_q == ALLOC && !io_alloc_ready && perf_alloc_stall_q != '1) begin
            perf_alloc_stall_q <= perf_alloc_stall_q + 32'd1;
         end
         if (state_q == ISSUE && !io_req_ready && perf_req_stall_q != '1) begin
            perf_req_stall_q <= perf_req_stall_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dma_read_req_scheduler.sv
// tb/tb_dma_read_req_scheduler.sv - directed table-driven bench for dma_read_req_scheduler
module tb_dma_read_req_scheduler;

   logic        clock;
   logic        reset;
   logic        io_cmd_valid;
   logic        io_cmd_ready;
   logic [5:0]  io_cmd_bits_tag_rob_id;
   logic [39:0] io_cmd_bits_vaddr;
   logic [14:0] io_cmd_bits_bytes;
   logic        io_alloc_valid;
   logic        io_alloc_ready;
   logic [5:0]  io_alloc_bits_tag_rob_id;
   logic [14:0] io_alloc_bits_bytes_to_read;
   logic        io_alloc_bits_cmd_id;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [39:0] io_req_bits_addr;
   logic [6:0]  io_req_bits_bytes;
   logic        io_req_bits_cmd_id;
   logic        io_busy;
`ifdef DMA_READ_REQ_SCHED_PERF_EN
   logic [31:0] io_perf_cmds;
   logic [31:0] io_perf_alloc_stall;
   logic [31:0] io_perf_req_stall;
`endif

   dma_read_req_scheduler dut (
      .clock                       (clock),
      .reset                       (reset),
      .io_cmd_valid                (io_cmd_valid),
      .io_cmd_ready                (io_cmd_ready),
      .io_cmd_bits_tag_rob_id      (io_cmd_bits_tag_rob_id),
      .io_cmd_bits_vaddr           (io_cmd_bits_vaddr),
      .io_cmd_bits_bytes           (io_cmd_bits_bytes),
      .io_alloc_valid              (io_alloc_valid),
      .io_alloc_ready              (io_alloc_ready),
      .io_alloc_bits_tag_rob_id    (io_alloc_bits_tag_rob_id),
      .io_alloc_bits_bytes_to_read (io_alloc_bits_bytes_to_read),
      .io_alloc_bits_cmd_id        (io_alloc_bits_cmd_id),
      .io_req_valid                (io_req_valid),
      .io_req_ready                (io_req_ready),
      .io_req_bits_addr            (io_req_bits_addr),
      .io_req_bits_bytes           (io_req_bits_bytes),
      .io_req_bits_cmd_id          (io_req_bits_cmd_id),
      .io_busy                     (io_busy)
`ifdef DMA_READ_REQ_SCHED_PERF_EN
      ,
      .io_perf_cmds                (io_perf_cmds),
      .io_perf_alloc_stall         (io_perf_alloc_stall),
      .io_perf_req_stall           (io_perf_req_stall)
`endif
   );

   typedef struct {
      logic [5:0]       tag;
      logic [39:0]      vaddr;
      logic [14:0]      bytes;
      logic             id;
      int               astall;
      int               rstall;
      int               nreq;
      logic [3:0][39:0] addr;
      logic [3:0][6:0]  len;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs[NVEC];

   int checks = 0;
   int errors = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void set_vec(input int i, input logic [5:0] tag, input logic [39:0] vaddr,
                                   input logic [14:0] bytes, input logic id, input int astall,
                                   input int rstall, input int nreq,
                                   input logic [39:0] a0, input logic [6:0] l0,
                                   input logic [39:0] a1, input logic [6:0] l1,
                                   input logic [39:0] a2, input logic [6:0] l2);
      vecs[i].tag    = tag;
      vecs[i].vaddr  = vaddr;
      vecs[i].bytes  = bytes;
      vecs[i].id     = id;
      vecs[i].astall = astall;
      vecs[i].rstall = rstall;
      vecs[i].nreq   = nreq;
      vecs[i].addr   = '0;
      vecs[i].len    = '0;
      vecs[i].addr[0] = a0;
      vecs[i].len[0]  = l0;
      vecs[i].addr[1] = a1;
      vecs[i].len[1]  = l1;
      vecs[i].addr[2] = a2;
      vecs[i].len[2]  = l2;
   endfunction

   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      @(negedge clock);
      chk($sformatf("v%0d cmd_ready_pre", i), io_cmd_ready, 1);
      io_cmd_valid           = 1'b1;
      io_cmd_bits_tag_rob_id = v.tag;
      io_cmd_bits_vaddr      = v.vaddr;
      io_cmd_bits_bytes      = v.bytes;
      @(negedge clock);
      io_cmd_valid = 1'b0;
      if (v.bytes == 0) begin
         chk($sformatf("v%0d zl busy", i), io_busy, 0);
         chk($sformatf("v%0d zl alloc_valid", i), io_alloc_valid, 0);
         chk($sformatf("v%0d zl req_valid", i), io_req_valid, 0);
         chk($sformatf("v%0d zl cmd_ready", i), io_cmd_ready, 1);
         @(negedge clock);
         chk($sformatf("v%0d zl alloc_valid2", i), io_alloc_valid, 0);
         chk($sformatf("v%0d zl busy2", i), io_busy, 0);
      end else begin
         for (int s = 0; s < v.astall; s++) begin
            io_alloc_ready = 1'b0;
            chk($sformatf("v%0d alloc_stall%0d valid", i, s), io_alloc_valid, 1);
            chk($sformatf("v%0d alloc_stall%0d tag", i, s), io_alloc_bits_tag_rob_id, v.tag);
            chk($sformatf("v%0d alloc_stall%0d bytes", i, s), io_alloc_bits_bytes_to_read, v.bytes);
            chk($sformatf("v%0d alloc_stall%0d cmd_ready", i, s), io_cmd_ready, 0);
            chk($sformatf("v%0d alloc_stall%0d req_valid", i, s), io_req_valid, 0);
            @(negedge clock);
         end
         chk($sformatf("v%0d alloc valid", i), io_alloc_valid, 1);
         chk($sformatf("v%0d alloc tag", i), io_alloc_bits_tag_rob_id, v.tag);
         chk($sformatf("v%0d alloc bytes", i), io_alloc_bits_bytes_to_read, v.bytes);
         chk($sformatf("v%0d alloc busy", i), io_busy, 1);
         io_alloc_ready       = 1'b1;
         io_alloc_bits_cmd_id = v.id;
         @(negedge clock);
         io_alloc_ready       = 1'b0;
         io_alloc_bits_cmd_id = ~v.id;
         for (int k = 0; k < v.nreq; k++) begin
            for (int s = 0; s < v.rstall; s++) begin
               io_req_ready = 1'b0;
               chk($sformatf("v%0d req%0d stall valid", i, k), io_req_valid, 1);
               chk($sformatf("v%0d req%0d stall addr", i, k), io_req_bits_addr, v.addr[k]);
               chk($sformatf("v%0d req%0d stall len", i, k), io_req_bits_bytes, v.len[k]);
               @(negedge clock);
            end
            io_req_ready = 1'b1;
            chk($sformatf("v%0d req%0d valid", i, k), io_req_valid, 1);
            chk($sformatf("v%0d req%0d addr", i, k), io_req_bits_addr, v.addr[k]);
            chk($sformatf("v%0d req%0d len", i, k), io_req_bits_bytes, v.len[k]);
            chk($sformatf("v%0d req%0d id", i, k), io_req_bits_cmd_id, v.id);
            chk($sformatf("v%0d req%0d alloc_valid", i, k), io_alloc_valid, 0);
            @(negedge clock);
            io_req_ready = 1'b0;
         end
         chk($sformatf("v%0d done req_valid", i), io_req_valid, 0);
         chk($sformatf("v%0d done cmd_ready", i), io_cmd_ready, 1);
         chk($sformatf("v%0d done busy", i), io_busy, 0);
      end
   endtask

   initial begin
      set_vec(0, 6'd5,  40'h1000,        15'd128, 1'b1, 0, 0, 2,
              40'h1000, 7'd64, 40'h1040, 7'd64, 40'h0, 7'd0);
      set_vec(1, 6'd9,  40'h1030,        15'd100, 1'b0, 0, 0, 3,
              40'h1030, 7'd16, 40'h1040, 7'd64, 40'h1080, 7'd20);
      set_vec(2, 6'd3,  40'h2008,        15'd70,  1'b1, 5, 1, 2,
              40'h2008, 7'd56, 40'h2040, 7'd14, 40'h0, 7'd0);
      set_vec(3, 6'd7,  40'h3000,        15'd0,   1'b0, 0, 0, 0,
              40'h0, 7'd0, 40'h0, 7'd0, 40'h0, 7'd0);
      set_vec(4, 6'd1,  40'hFF_FFFF_FFE0, 15'd64, 1'b0, 0, 0, 2,
              40'hFF_FFFF_FFE0, 7'd32, 40'h0, 7'd32, 40'h0, 7'd0);
      set_vec(5, 6'd62, 40'h5005,        15'd3,   1'b1, 0, 0, 1,
              40'h5005, 7'd3, 40'h0, 7'd0, 40'h0, 7'd0);
      set_vec(6, 6'd33, 40'h103F,        15'd1,   1'b0, 0, 0, 1,
              40'h103F, 7'd1, 40'h0, 7'd0, 40'h0, 7'd0);

      reset                  = 1'b1;
      io_cmd_valid           = 1'b0;
      io_cmd_bits_tag_rob_id = '0;
      io_cmd_bits_vaddr      = '0;
      io_cmd_bits_bytes      = '0;
      io_alloc_ready         = 1'b0;
      io_alloc_bits_cmd_id   = 1'b0;
      io_req_ready           = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      chk("rst cmd_ready", io_cmd_ready, 1);
      chk("rst alloc_valid", io_alloc_valid, 0);
      chk("rst req_valid", io_req_valid, 0);
      chk("rst busy", io_busy, 0);
      chk("rst alloc_tag", io_alloc_bits_tag_rob_id, 0);
      chk("rst alloc_bytes", io_alloc_bits_bytes_to_read, 0);
      chk("rst req_addr", io_req_bits_addr, 0);
      chk("rst req_bytes", io_req_bits_bytes, 0);
      chk("rst req_id", io_req_bits_cmd_id, 0);
`ifdef DMA_READ_REQ_SCHED_PERF_EN
      chk("rst perf_cmds", io_perf_cmds, 0);
      chk("rst perf_alloc_stall", io_perf_alloc_stall, 0);
      chk("rst perf_req_stall", io_perf_req_stall, 0);
`endif

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i);
      end

`ifdef DMA_READ_REQ_SCHED_PERF_EN
      chk("perf_cmds", io_perf_cmds, 6);
      chk("perf_alloc_stall", io_perf_alloc_stall, 5);
      chk("perf_req_stall", io_perf_req_stall, 2);
`endif

      // Reset while in ISSUE, after the first of three requests has fired.
      @(negedge clock);
      io_cmd_valid           = 1'b1;
      io_cmd_bits_tag_rob_id = 6'd2;
      io_cmd_bits_vaddr      = 40'h4000;
      io_cmd_bits_bytes      = 15'd192;
      @(negedge clock);
      io_cmd_valid   = 1'b0;
      chk("mid alloc_valid", io_alloc_valid, 1);
      io_alloc_ready       = 1'b1;
      io_alloc_bits_cmd_id = 1'b1;
      @(negedge clock);
      io_alloc_ready = 1'b0;
      io_req_ready   = 1'b1;
      chk("mid req0 addr", io_req_bits_addr, 40'h4000);
      chk("mid req0 len", io_req_bits_bytes, 64);
      @(negedge clock);
      io_req_ready = 1'b0;
      chk("mid req1 valid", io_req_valid, 1);
      chk("mid req1 addr", io_req_bits_addr, 40'h4040);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid rst req_valid", io_req_valid, 0);
      chk("mid rst alloc_valid", io_alloc_valid, 0);
      chk("mid rst cmd_ready", io_cmd_ready, 1);
      chk("mid rst busy", io_busy, 0);
      chk("mid rst req_bytes", io_req_bits_bytes, 0);
`ifdef DMA_READ_REQ_SCHED_PERF_EN
      chk("mid rst perf_cmds", io_perf_cmds, 0);
`endif
      run_vec(0);
`ifdef DMA_READ_REQ_SCHED_PERF_EN
      chk("post rst perf_cmds", io_perf_cmds, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
